// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks the SSM2603 register-write table, handing each byte to the I2C engine via start/ready.
// Define SEQ_RETRY_EN to retry a timed-out entry up to three times and expose retry_cnt.
module codec_init_sequencer #(
    parameter logic [6:0] DEV_ADDR      = 7'h1A,
    parameter int         NUM_WRITES    = 10,
    parameter int         POWERUP_DELAY = 100000,
    parameter int         GAP_DELAY     = 1000,
    parameter int         TIMEOUT       = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    output logic       start,
    output logic [6:0] address,
    output logic [7:0] data,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic       error,
`ifdef SEQ_RETRY_EN
    output logic [1:0] retry_cnt,
`endif
    output logic [3:0] index
);
    localparam logic [3:0] PWR_WAIT  = 4'd0;
    localparam logic [3:0] WAIT_IDLE = 4'd1;
    localparam logic [3:0] REQ0      = 4'd2;
    localparam logic [3:0] ACK0      = 4'd3;
    localparam logic [3:0] REQ1      = 4'd4;
    localparam logic [3:0] ACK1      = 4'd5;
    localparam logic [3:0] GAP       = 4'd6;
    localparam logic [3:0] DONE      = 4'd7;
    localparam logic [3:0] ERROR     = 4'd8;
    localparam logic [31:0] PWR_LAST = 32'(POWERUP_DELAY - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_DELAY - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_WRITES - 1);

    logic [3:0]  state, nxt;
    logic [31:0] cnt;
    logic [15:0] ent;
    logic        ready_m, ready_s, tmo, can_retry, advance;

    assign address = DEV_ADDR;

    // Entry layout {reg[6:0], val[8:0]}: the upper byte carries val[8].
    always_comb begin
        case (index)
            4'd0:    ent = {7'd15, 9'h000};
            4'd1:    ent = {7'd6,  9'h010};
            4'd2:    ent = {7'd0,  9'h017};
            4'd3:    ent = {7'd1,  9'h017};
            4'd4:    ent = {7'd2,  9'h079};
            4'd5:    ent = {7'd3,  9'h079};
            4'd6:    ent = {7'd4,  9'h012};
            4'd7:    ent = {7'd5,  9'h000};
            4'd8:    ent = {7'd7,  9'h00A};
            4'd9:    ent = {7'd9,  9'h001};
            default: ent = 16'h0000;
        endcase
    end

    assign tmo = (state inside {WAIT_IDLE, REQ0, ACK0, REQ1, ACK1}) && cnt == TO_LAST;
    assign advance = state == GAP && nxt == WAIT_IDLE;

`ifdef SEQ_RETRY_EN
    assign can_retry = retry_cnt != 2'd3;
`else
    assign can_retry = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            PWR_WAIT:  nxt = cnt == PWR_LAST ? WAIT_IDLE : PWR_WAIT;
            WAIT_IDLE: nxt = ready_s ? REQ0 : WAIT_IDLE;
            REQ0:      nxt = ready_s ? REQ0 : ACK0;
            ACK0:      nxt = ready_s ? REQ1 : ACK0;
            REQ1:      nxt = ready_s ? REQ1 : ACK1;
            ACK1:      nxt = ready_s ? GAP : ACK1;
            GAP:       nxt = cnt != GAP_LAST ? GAP : index == LAST_IDX ? DONE : WAIT_IDLE;
            default:   nxt = state;
        endcase
        if (tmo)
            nxt = can_retry ? WAIT_IDLE : ERROR;
    end

    // Counter restarts on every state entry, including a retry that re-enters WAIT_IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_m <= 1'b0;
            ready_s <= 1'b0;
            state   <= PWR_WAIT;
            cnt     <= '0;
            start   <= 1'b0;
            data    <= '0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            index   <= '0;
        end else begin
            ready_m <= ready;
            ready_s <= ready_m;
            state   <= nxt;
            cnt     <= (nxt != state || tmo) ? '0 : cnt + 32'd1;
            start   <= nxt == REQ0 || nxt == REQ1;
            busy    <= nxt != DONE && nxt != ERROR;
            done    <= nxt == DONE;
            error   <= nxt == ERROR;
            if (nxt == REQ0 && state != REQ0)
                {data, last} <= {ent[15:8], 1'b0};
            if (nxt == REQ1 && state != REQ1)
                {data, last} <= {ent[7:0], 1'b1};
            if (advance)
                index <= index + 4'd1;
        end
    end

`ifdef SEQ_RETRY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retry_cnt <= 2'd0;
        else if (advance)
            retry_cnt <= 2'd0;
        else if (tmo && can_retry)
            retry_cnt <= retry_cnt + 2'd1;
    end
`endif

endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: directed bench with an engine model and a byte scoreboard for codec_init_sequencer.
module tb_codec_init_sequencer;
    logic       clk = 1'b0, reset = 1'b0, ready;
    logic       start, last, busy, done, error;
    logic [6:0] address;
    logic [7:0] data;
    logic [3:0] index;
    logic       reset2 = 1'b0, ready2 = 1'b1;
    logic       start2, last2, busy2, done2, error2;
    logic [6:0] address2;
    logic [7:0] data2;
    logic [3:0] index2;
`ifdef SEQ_RETRY_EN
    logic [1:0] retry_cnt, retry_cnt2, rmax;
`endif
    int         n_cmp = 0, n_err = 0;
    int         ign_n = 0, ign_seen = 0;
    logic [3:0] ign_idx = 4'd0;
    logic       eng_hold = 1'b1;
    logic [8:0] sb[$];
    logic [8:0] sb2[$];
    logic [8:0] stream [20] = '{9'h01E, 9'h100, 9'h00C, 9'h110, 9'h000, 9'h117, 9'h002, 9'h117,
                                9'h004, 9'h179, 9'h006, 9'h179, 9'h008, 9'h112, 9'h00A, 9'h100,
                                9'h00E, 9'h10A, 9'h012, 9'h101};

    always #5 clk = ~clk;

    codec_init_sequencer #(.POWERUP_DELAY(10), .GAP_DELAY(4), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .ready(ready), .start(start), .address(address), .data(data),
        .last(last), .busy(busy), .done(done), .error(error),
`ifdef SEQ_RETRY_EN
        .retry_cnt(retry_cnt),
`endif
        .index(index)
    );

    codec_init_sequencer #(.NUM_WRITES(1), .POWERUP_DELAY(10), .GAP_DELAY(4), .TIMEOUT(50)) dut1 (
        .clk(clk), .reset(reset2), .ready(ready2), .start(start2), .address(address2), .data(data2),
        .last(last2), .busy(busy2), .done(done2), .error(error2),
`ifdef SEQ_RETRY_EN
        .retry_cnt(retry_cnt2),
`endif
        .index(index2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eng_wait(input int n, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!reset) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Engine model: drops ready 3 cycles after a request, releases it 20 cycles later.
    task automatic serve();
        logic [8:0] cap;
        logic       ok;
        cap = {last, data};
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0)
            chk("byte_stream", 32'(cap), 32'(sb.pop_front()));
        eng_wait(3, ok);
        if (!ok) return;
        ready = 1'b0;
        eng_wait(2, ok);
        if (!ok) return;
        chk("start_held_2_after_ready_fall", 32'(start), 1);
        eng_wait(1, ok);
        if (!ok) return;
        chk("start_drop_after_sync", 32'(start), 0);
        eng_wait(17, ok);
        if (!ok) return;
        chk("data_stable_req_ack", 32'({last, data}), 32'(cap));
        ready = 1'b1;
    endtask

    initial begin : engine
        logic sq;
        sq = 1'b0;
        ready = 1'b0;
        forever begin
            @(negedge clk);
            ready = !eng_hold;
            if (!reset)
                ign_seen = 0;
`ifdef SEQ_RETRY_EN
            if (!reset)
                rmax = 2'd0;
            else if (retry_cnt > rmax)
                rmax = retry_cnt;
`endif
            if (start && !sq && reset) begin
                if (ign_seen < ign_n && index == ign_idx)
                    ign_seen++;
                else
                    serve();
            end
            sq = start;
        end
    end

    initial begin
        int   b;
        logic saw;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_index", 32'(index), 0);
        chk("rst_data", 32'({last, data}), 0);
        chk("address", 32'(address), 32'h1A);
        reset = 1'b1;
        foreach (stream[i]) sb.push_back(stream[i]);
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw |= start;
        end
        chk("no_start_while_ready_low", 32'(saw), 0);
        chk("busy_after_release", 32'(busy), 1);
        eng_hold = 1'b0;
        b = 0;
        do begin @(negedge clk); b++; end while (!(start && last && index == 4'd5) && b < 2000);
        chk("reach_entry5_req1", 32'(start && last && index == 4'd5), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_start", 32'(start), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_index", 32'(index), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (stream[i]) sb.push_back(stream[i]);
        b = 0;
        do begin @(negedge clk); b++; end while (!done && b < 3000);
        chk("run_done", 32'(done), 1);
        chk("run_busy", 32'(busy), 0);
        chk("run_error", 32'(error), 0);
        chk("run_index", 32'(index), 9);
        chk("run_sb_empty", 32'(sb.size()), 0);
        chk("done_err_excl", 32'(done & error), 0);

        reset = 1'b0;
        sb.delete();
        ign_idx = 4'd3;
`ifdef SEQ_RETRY_EN
        ign_n = 4;
`else
        ign_n = 1;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (stream[i]) sb.push_back(stream[i]);
        b = 0;
        do begin @(negedge clk); b++; end while (!(start && index == 4'd3) && b < 2000);
        chk("reach_entry3_req0", 32'(start && index == 4'd3), 1);
`ifdef SEQ_RETRY_EN
        b = 0;
        do begin @(negedge clk); b++; end while (!error && b < 1000);
        chk("retry_exhaust_error", 32'(error), 1);
        chk("retry_exhaust_cnt", 32'(retry_cnt), 3);
`else
        repeat (49) @(negedge clk);
        chk("no_error_before_timeout", 32'(error), 0);
        @(negedge clk);
        chk("error_at_timeout", 32'(error), 1);
`endif
        chk("to_start", 32'(start), 0);
        chk("to_done", 32'(done), 0);
        chk("to_busy", 32'(busy), 0);
        chk("to_index", 32'(index), 3);

`ifdef SEQ_RETRY_EN
        reset = 1'b0;
        sb.delete();
        ign_idx = 4'd2;
        ign_n = 2;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        foreach (stream[i]) sb.push_back(stream[i]);
        b = 0;
        do begin @(negedge clk); b++; end while (!done && b < 4000);
        chk("retry_done", 32'(done), 1);
        chk("retry_error", 32'(error), 0);
        chk("retry_max", 32'(rmax), 2);
        chk("retry_sb_empty", 32'(sb.size()), 0);
`endif

        reset2 = 1'b1;
        sb2.push_back(9'h01E);
        sb2.push_back(9'h100);
        for (int k = 0; k < 2; k++) begin
            b = 0;
            do begin @(negedge clk); b++; end while (!start2 && b < 200);
            chk("n1_start", 32'(start2), 1);
            chk("n1_byte", 32'({last2, data2}), 32'(sb2.pop_front()));
            ready2 = 1'b0;
            b = 0;
            do begin @(negedge clk); b++; end while (start2 && b < 20);
            chk("n1_start_drop", 32'(start2), 0);
            ready2 = 1'b1;
        end
        repeat (6) @(negedge clk);
        chk("n1_not_done_in_gap", 32'(done2), 0);
        @(negedge clk);
        chk("n1_done", 32'(done2), 1);
        chk("n1_busy", 32'(busy2), 0);
        chk("n1_error", 32'(error2), 0);
        chk("n1_index", 32'(index2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
